// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
// Holds the state encoding, the divider field widths and the power-up divider codes.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      RST_HOLD,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAULT
   } pll_state_e;

   localparam int IDIV_W  = 6;
   localparam int FBDIV_W = 6;
   localparam int MDIV_W  = 7;
   localparam int ODIV_W  = 7;

   localparam logic [IDIV_W-1:0]  IDIV_DEFAULT  = 6'd1;
   localparam logic [FBDIV_W-1:0] FBDIV_DEFAULT = 6'd1;
   localparam logic [MDIV_W-1:0]  MDIV_DEFAULT  = 7'd8;
   localparam logic [ODIV_W-1:0]  ODIV0_DEFAULT = 7'd16;

   typedef struct packed {
      logic [IDIV_W-1:0]  idiv;
      logic [FBDIV_W-1:0] fbdiv;
      logic [MDIV_W-1:0]  mdiv;
      logic [ODIV_W-1:0]  odiv0;
   } pll_div_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous status inputs such as PLL LOCK.
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL bring-up and reconfiguration sequencer: applies divider codes, pulses PLL reset,
// qualifies LOCK and only then releases the downstream SoC reset.
module pll_reconfig_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int                  RST_CYCLES    = 16,
   parameter int                  LOCK_TIMEOUT  = 65535,
   parameter int                  STABLE_CYCLES = 256,
   parameter int                  MAX_RETRY     = 3,
   parameter logic [IDIV_W-1:0]   DEF_IDIV      = IDIV_DEFAULT,
   parameter logic [FBDIV_W-1:0]  DEF_FBDIV     = FBDIV_DEFAULT,
   parameter logic [MDIV_W-1:0]   DEF_MDIV      = MDIV_DEFAULT,
   parameter logic [ODIV_W-1:0]   DEF_ODIV0     = ODIV0_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [IDIV_W-1:0]  cfg_idiv,
   input  logic [FBDIV_W-1:0] cfg_fbdiv,
   input  logic [MDIV_W-1:0]  cfg_mdiv,
   input  logic [ODIV_W-1:0]  cfg_odiv0,
   input  logic               pll_lock,
   output logic               pll_reset,
   output logic [IDIV_W-1:0]  pll_idsel,
   output logic [FBDIV_W-1:0] pll_fbdsel,
   output logic [MDIV_W-1:0]  pll_mdsel,
   output logic [ODIV_W-1:0]  pll_odsel0,
   output logic               sys_rst_n,
   output logic               locked,
   output logic               err_timeout,
   output logic               lock_lost
);

   localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int RETRY_W = $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(CNT_MAX);
   localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

   localparam pll_div_t DIV_DEFAULT = pll_div_t'({DEF_IDIV, DEF_FBDIV, DEF_MDIV, DEF_ODIV0});

   pll_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cntInc;
   logic [RETRY_W-1:0] retry_q, retry_d, retryInc;
   logic               errTimeout_q, errTimeout_d;
   logic               lockLost_q, lockLost_d;
   pll_div_t           pend_q, pend_d;
   pll_div_t           div_q;
   pll_div_t           cfgIn;
   logic               pllReset_q, sysRstN_q, locked_q;
   logic               lockS;
   logic               cfgReady;
   logic               accept;

   sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
   ) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (pll_lock),
      .q_o   (lockS)
   );

   assign cfgIn    = pll_div_t'({cfg_idiv, cfg_fbdiv, cfg_mdiv, cfg_odiv0});
   assign cfgReady = (state_q == RUN) || (state_q == FAULT);
   assign accept   = cfgReady && cfg_valid;
   assign cntInc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
   assign retryInc = retry_q + RETRY_W'(1);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      retry_d      = retry_q;
      errTimeout_d = errTimeout_q;
      lockLost_d   = lockLost_q;
      pend_d       = pend_q;

      case (state_q)
         RST_HOLD: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cntInc;
            end
         end
         WAIT_LOCK: begin
            // A lock seen on the timeout cycle still counts as success.
            if (lockS) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               retry_d = retryInc;
               cnt_d   = '0;
               if (retryInc < RETRY_LIM) begin
                  state_d = RST_HOLD;
               end else begin
                  state_d      = FAULT;
                  errTimeout_d = 1'b1;
               end
            end else begin
               cnt_d = cntInc;
            end
         end
         STABLE: begin
            if (!lockS) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STB_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cntInc;
            end
         end
         RUN: begin
            if (!lockS) begin
               state_d    = RST_HOLD;
               cnt_d      = '0;
               retry_d    = '0;
               lockLost_d = 1'b1;
            end
         end
         FAULT: begin
         end
         default: begin
            state_d = RST_HOLD;
            cnt_d   = '0;
         end
      endcase

      // Acceptance overrides the lock-loss path but leaves lock_lost as already decided.
      if (accept) begin
         state_d      = RST_HOLD;
         cnt_d        = '0;
         retry_d      = '0;
         errTimeout_d = 1'b0;
         pend_d       = cfgIn;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RST_HOLD;
         cnt_q        <= '0;
         retry_q      <= '0;
         errTimeout_q <= 1'b0;
         lockLost_q   <= 1'b0;
         pend_q       <= DIV_DEFAULT;
         div_q        <= DIV_DEFAULT;
         pllReset_q   <= 1'b1;
         sysRstN_q    <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         errTimeout_q <= errTimeout_d;
         lockLost_q   <= lockLost_d;
         pend_q       <= pend_d;
         pllReset_q   <= (state_d == RST_HOLD) || (state_d == FAULT);
         sysRstN_q    <= (state_d == RUN);
         locked_q     <= (state_d == RUN);
         // Dividers only move once PLL reset is already asserted.
         if (state_q == RST_HOLD) begin
            div_q <= pend_q;
         end
      end
   end

   assign cfg_ready   = cfgReady;
   assign pll_reset   = pllReset_q;
   assign sys_rst_n   = sysRstN_q;
   assign locked      = locked_q;
   assign err_timeout = errTimeout_q;
   assign lock_lost   = lockLost_q;
   assign pll_idsel   = div_q.idiv;
   assign pll_fbdsel  = div_q.fbdiv;
   assign pll_mdsel   = div_q.mdiv;
   assign pll_odsel0  = div_q.odiv0;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl with randomized lock timing and config codes,
// checked against timing and divider expectations derived from the sequencing rules.
module tb_pll_reconfig_ctrl;

   localparam int RST_CYC = 4;
   localparam int TO      = 100;
   localparam int STB     = 8;
   localparam int MAXR    = 2;

   // Expected latencies measured in clocks from the moment the bench changes pll_lock.
   localparam int REL_TICKS  = 2 + STB + 1;
   localparam int DROP_TICKS = 2 + 1;

   localparam logic [25:0] DIV_DEF = {6'd1, 6'd1, 7'd8, 7'd16};

   logic       clk;
   logic       rst_n;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [5:0] cfg_idiv;
   logic [5:0] cfg_fbdiv;
   logic [6:0] cfg_mdiv;
   logic [6:0] cfg_odiv0;
   logic       pll_lock;
   logic       pll_reset;
   logic [5:0] pll_idsel;
   logic [5:0] pll_fbdsel;
   logic [6:0] pll_mdsel;
   logic [6:0] pll_odsel0;
   logic       sys_rst_n;
   logic       locked;
   logic       err_timeout;
   logic       lock_lost;

   int          nChecks;
   int          nFails;
   logic [25:0] expDiv;
   logic [25:0] divOut;

   assign divOut = {pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel0};

   pll_reconfig_ctrl #(
      .RST_CYCLES    (RST_CYC),
      .LOCK_TIMEOUT  (TO),
      .STABLE_CYCLES (STB),
      .MAX_RETRY     (MAXR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_idiv    (cfg_idiv),
      .cfg_fbdiv   (cfg_fbdiv),
      .cfg_mdiv    (cfg_mdiv),
      .cfg_odiv0   (cfg_odiv0),
      .pll_lock    (pll_lock),
      .pll_reset   (pll_reset),
      .pll_idsel   (pll_idsel),
      .pll_fbdsel  (pll_fbdsel),
      .pll_mdsel   (pll_mdsel),
      .pll_odsel0  (pll_odsel0),
      .sys_rst_n   (sys_rst_n),
      .locked      (locked),
      .err_timeout (err_timeout),
      .lock_lost   (lock_lost)
   );

   // Free-running reference clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case some wait is never satisfied.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic curSig(input int sel);
      return (sel == 0) ? pll_reset : sys_rst_n;
   endfunction

   // Counts clocks until the chosen output (0: pll_reset, 1: sys_rst_n) equals val; -1 if it never does.
   task automatic ticksUntil(input int sel, input logic val, input int limit, output int n);
      logic hit;
      hit = 1'b0;
      n   = 0;
      while (!hit && n <= limit) begin
         tick();
         n++;
         hit = (curSig(sel) === val);
      end
      if (!hit) n = -1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [25:0] codes);
      cfg_valid = valid;
      {cfg_idiv, cfg_fbdiv, cfg_mdiv, cfg_odiv0} = codes;
   endtask

   function automatic logic [25:0] randCodes();
      return {6'($urandom_range(1, 63)), 6'($urandom_range(1, 63)),
              7'($urandom_range(1, 127)), 7'($urandom_range(1, 127))};
   endfunction

   // Waits d clocks in WAIT_LOCK, raises lock, and measures clocks to SoC reset release.
   task automatic bringUp(input int d, output int nRel);
      repeat (d) tick();
      pll_lock = 1'b1;
      ticksUntil(1, 1'b1, 300, nRel);
   endtask

   task automatic test_reset();
      repeat (2) tick();
      nChecks++;
      if ({pll_reset, sys_rst_n, locked, cfg_ready, err_timeout, lock_lost} !== 6'b100000) begin
         nFails++;
         $display("[TB] FAIL reset_flags: got %b expected 100000",
                  {pll_reset, sys_rst_n, locked, cfg_ready, err_timeout, lock_lost});
      end
      nChecks++;
      if (divOut !== DIV_DEF) begin
         nFails++;
         $display("[TB] FAIL reset_div: got %h expected %h", divOut, DIV_DEF);
      end
   endtask

   task automatic test_powerup();
      int n;
      int d;
      rst_n = 1'b1;
      ticksUntil(0, 1'b0, 50, n);
      nChecks++;
      if (n !== RST_CYC) begin
         nFails++;
         $display("[TB] FAIL powerup_rst_len: got %0d expected %0d", n, RST_CYC);
      end
      d = $urandom_range(3, 30);
      bringUp(d, n);
      nChecks++;
      if (n !== REL_TICKS) begin
         nFails++;
         $display("[TB] FAIL powerup_release: got %0d expected %0d (lock delay %0d)", n, REL_TICKS, d);
      end
      nChecks++;
      if ({locked, cfg_ready, pll_reset, err_timeout, lock_lost} !== 5'b11000) begin
         nFails++;
         $display("[TB] FAIL powerup_run_flags: got %b expected 11000",
                  {locked, cfg_ready, pll_reset, err_timeout, lock_lost});
      end
      nChecks++;
      if (divOut !== expDiv) begin
         nFails++;
         $display("[TB] FAIL powerup_div: got %h expected %h", divOut, expDiv);
      end
   endtask

   task automatic test_lock_loss();
      int n;
      for (int it = 0; it < 3; it++) begin
         pll_lock = 1'b0;
         ticksUntil(1, 1'b0, 20, n);
         nChecks++;
         if (n !== DROP_TICKS) begin
            nFails++;
            $display("[TB] FAIL lossdrop_latency: got %0d expected %0d", n, DROP_TICKS);
         end
         nChecks++;
         if ({pll_reset, locked, lock_lost, cfg_ready} !== 4'b1010) begin
            nFails++;
            $display("[TB] FAIL lossdrop_flags: got %b expected 1010",
                     {pll_reset, locked, lock_lost, cfg_ready});
         end
         ticksUntil(0, 1'b0, 50, n);
         nChecks++;
         if (n !== RST_CYC) begin
            nFails++;
            $display("[TB] FAIL loss_rst_len: got %0d expected %0d", n, RST_CYC);
         end
         bringUp($urandom_range(0, 40), n);
         nChecks++;
         if (n !== REL_TICKS || lock_lost !== 1'b1 || locked !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL loss_recover: got ticks %0d lost %b locked %b expected %0d 1 1",
                     n, lock_lost, locked, REL_TICKS);
         end
      end
   endtask

   task automatic test_reconfig();
      int          n;
      logic [25:0] codes;
      codes = randCodes();
      nChecks++;
      if (cfg_ready !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL cfg_ready_run: got %b expected 1", cfg_ready);
      end
      applyStimulus(1'b1, codes);
      tick();
      expDiv = codes;
      pll_lock = 1'b0;
      applyStimulus(1'b0, randCodes());
      nChecks++;
      if ({sys_rst_n, locked, cfg_ready, pll_reset} !== 4'b0001) begin
         nFails++;
         $display("[TB] FAIL accept_flags: got %b expected 0001",
                  {sys_rst_n, locked, cfg_ready, pll_reset});
      end
      tick();
      nChecks++;
      if (divOut !== expDiv || pll_reset !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL accept_div: got %h reset %b expected %h reset 1", divOut, pll_reset, expDiv);
      end
      ticksUntil(0, 1'b0, 50, n);
      nChecks++;
      if (n !== RST_CYC - 1) begin
         nFails++;
         $display("[TB] FAIL accept_rst_len: got %0d expected %0d", n, RST_CYC - 1);
      end
      applyStimulus(1'b1, randCodes());
      for (int i = 0; i < 5; i++) begin
         tick();
         nChecks++;
         if (cfg_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL wait_cfg_ready: got %b expected 0 (cycle %0d)", cfg_ready, i);
         end
      end
      applyStimulus(1'b0, 26'd0);
      nChecks++;
      if (divOut !== expDiv) begin
         nFails++;
         $display("[TB] FAIL wait_div_hold: got %h expected %h", divOut, expDiv);
      end
      bringUp($urandom_range(0, 20), n);
      nChecks++;
      if (n !== REL_TICKS || divOut !== expDiv) begin
         nFails++;
         $display("[TB] FAIL reconfig_release: got ticks %0d div %h expected %0d div %h",
                  n, divOut, REL_TICKS, expDiv);
      end
   endtask

   task automatic test_async_reset();
      int n;
      pll_lock = 1'b0;
      ticksUntil(1, 1'b0, 20, n);
      ticksUntil(0, 1'b0, 50, n);
      repeat ($urandom_range(5, 40)) tick();
      #2;
      rst_n = 1'b0;
      #1;
      expDiv = DIV_DEF;
      nChecks++;
      if ({pll_reset, sys_rst_n, locked, cfg_ready, err_timeout, lock_lost} !== 6'b100000) begin
         nFails++;
         $display("[TB] FAIL async_flags: got %b expected 100000",
                  {pll_reset, sys_rst_n, locked, cfg_ready, err_timeout, lock_lost});
      end
      nChecks++;
      if (divOut !== expDiv) begin
         nFails++;
         $display("[TB] FAIL async_div: got %h expected %h", divOut, expDiv);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_glitch();
      int n;
      int j;
      ticksUntil(0, 1'b0, 50, n);
      nChecks++;
      if (n !== RST_CYC) begin
         nFails++;
         $display("[TB] FAIL glitch_rst_len: got %0d expected %0d", n, RST_CYC);
      end
      repeat ($urandom_range(0, 20)) tick();
      pll_lock = 1'b1;
      j = $urandom_range(1, STB);
      repeat (j) tick();
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      ticksUntil(1, 1'b1, 300, n);
      nChecks++;
      if (n !== REL_TICKS) begin
         nFails++;
         $display("[TB] FAIL glitch_release: got %0d expected %0d (high for %0d)", n, REL_TICKS, j);
      end
      nChecks++;
      if ({locked, err_timeout, lock_lost, pll_reset} !== 4'b1000) begin
         nFails++;
         $display("[TB] FAIL glitch_flags: got %b expected 1000",
                  {locked, err_timeout, lock_lost, pll_reset});
      end
   endtask

   task automatic test_coincide();
      int          n;
      logic [25:0] codes;
      codes = randCodes();
      pll_lock = 1'b0;
      tick();
      tick();
      nChecks++;
      if (cfg_ready !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL coincide_ready: got %b expected 1", cfg_ready);
      end
      applyStimulus(1'b1, codes);
      tick();
      expDiv = codes;
      applyStimulus(1'b0, 26'd0);
      nChecks++;
      if ({lock_lost, sys_rst_n, locked, pll_reset} !== 4'b1001) begin
         nFails++;
         $display("[TB] FAIL coincide_flags: got %b expected 1001",
                  {lock_lost, sys_rst_n, locked, pll_reset});
      end
      tick();
      nChecks++;
      if (divOut !== expDiv) begin
         nFails++;
         $display("[TB] FAIL coincide_div: got %h expected %h", divOut, expDiv);
      end
      ticksUntil(0, 1'b0, 50, n);
      bringUp($urandom_range(0, 20), n);
      nChecks++;
      if (n !== REL_TICKS) begin
         nFails++;
         $display("[TB] FAIL coincide_release: got %0d expected %0d", n, REL_TICKS);
      end
   endtask

   task automatic test_timeout();
      int          n;
      logic [25:0] codes;
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      tick();
      rst_n  = 1'b1;
      expDiv = DIV_DEF;
      for (int a = 0; a < MAXR; a++) begin
         ticksUntil(0, 1'b0, 50, n);
         nChecks++;
         if (n !== RST_CYC) begin
            nFails++;
            $display("[TB] FAIL to_rst_len: got %0d expected %0d (attempt %0d)", n, RST_CYC, a);
         end
         ticksUntil(0, 1'b1, 300, n);
         nChecks++;
         if (n !== TO) begin
            nFails++;
            $display("[TB] FAIL to_wait_len: got %0d expected %0d (attempt %0d)", n, TO, a);
         end
         nChecks++;
         if (err_timeout !== (a == MAXR - 1)) begin
            nFails++;
            $display("[TB] FAIL to_err_flag: got %b expected %b (attempt %0d)",
                     err_timeout, (a == MAXR - 1), a);
         end
      end
      repeat ($urandom_range(6, 20)) tick();
      nChecks++;
      if ({pll_reset, cfg_ready, sys_rst_n, err_timeout} !== 4'b1101) begin
         nFails++;
         $display("[TB] FAIL fault_flags: got %b expected 1101",
                  {pll_reset, cfg_ready, sys_rst_n, err_timeout});
      end
      codes = randCodes();
      applyStimulus(1'b1, codes);
      tick();
      expDiv = codes;
      applyStimulus(1'b0, 26'd0);
      nChecks++;
      if ({err_timeout, cfg_ready, pll_reset} !== 3'b001) begin
         nFails++;
         $display("[TB] FAIL fault_accept: got %b expected 001", {err_timeout, cfg_ready, pll_reset});
      end
      tick();
      nChecks++;
      if (divOut !== expDiv) begin
         nFails++;
         $display("[TB] FAIL fault_div: got %h expected %h", divOut, expDiv);
      end
      ticksUntil(0, 1'b0, 50, n);
      bringUp($urandom_range(0, 20), n);
      nChecks++;
      if (n !== REL_TICKS || locked !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL fault_recover: got ticks %0d locked %b expected %0d 1", n, locked, REL_TICKS);
      end
   endtask

   initial begin
      nChecks  = 0;
      nFails   = 0;
      expDiv   = DIV_DEF;
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      applyStimulus(1'b0, 26'd0);
      $display("[TB] starting pll_reconfig_ctrl bench");
      test_reset();
      test_powerup();
      test_lock_loss();
      test_reconfig();
      test_async_reset();
      test_glitch();
      test_coincide();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
